vline_irq: RTL and testbench
============================

VLINE_IRQ -- requirements
Module: vline_irq

Interface
REQ-001 SHALL have one clock and a synchronous, active-low reset: CLK (input, 1 bit, all state on rising edge) and RESETL (input, 1 bit); reset is sampled on the rising edge of CLK.
REQ-002 HTICK  in  1  single-cycle pulse marking end of a display line (line advance).
REQ-003 VTOTAL  in  9  index of last line in frame; held static except between frames.
REQ-004 DIN  in  8  CPU write data.
REQ-005 WR_LO  in  1  write strobe: DIN[7:0] -> compare bits [7:0].
REQ-006 WR_HI  in  1  write strobe: DIN[0] -> compare bit 8, DIN[7] -> IRQ_EN.
REQ-007 IRQ_ACK  in  1  single-cycle CPU acknowledge.
REQ-008 VCNT  out  9  current line number.
REQ-009 FRAME  out  1  one-cycle pulse, coincident with VCNT becoming 0 on a wrap.
REQ-010 CMP_Q  out  9  active compare value (readback).
REQ-011 IRQ  out  1  line-match interrupt request, level, held until acknowledged.
REQ-012 OVR  out  1  sticky overrun flag.

Function
REQ-013 On HTICK, if VCNT >= VTOTAL then VCNT SHALL become 0 and FRAME SHALL pulse in that same cycle; otherwise VCNT SHALL increment by 1. Without HTICK, VCNT holds.
REQ-014 The >= comparison SHALL also cover VTOTAL being lowered below VCNT: the next HTICK wraps VCNT to 0.
REQ-015 The match SHALL be evaluated only on HTICK, against the next VCNT value: match = IRQ_EN AND (next VCNT == active compare).
REQ-016 On a match, IRQ SHALL be 1 in the same cycle in which VCNT shows the matching line, i.e. 1 cycle after HTICK.
REQ-017 A compare write SHALL never raise IRQ by itself, even if the written value equals the current VCNT.
REQ-018 IRQ_ACK SHALL clear IRQ and OVR on the next edge.
REQ-019 If a match and IRQ_ACK occur in the same cycle, IRQ SHALL end at 1 (the new event wins) and OVR SHALL end at 0.
REQ-020 A match while IRQ is already 1 and no IRQ_ACK is present SHALL set OVR; OVR then stays at 1 until acknowledged or reset.
REQ-021 Clearing IRQ_EN SHALL block new matches only; a pending IRQ or OVR SHALL remain set.
REQ-022 WR_LO and WR_HI in the same cycle SHALL update both halves; an IRQ_ACK during a write SHALL act independently of it.
REQ-023 All arithmetic on VCNT and the compare value SHALL be 9-bit unsigned; there is no carry out of bit 8.

Reset
REQ-024 While RESETL = 0 at a clock edge, all state SHALL take its reset value: VCNT = 0, FRAME = 0, IRQ = 0, OVR = 0, IRQ_EN = 0, active compare = 0x000 (CMP_Q = 0), shadow compare = 0x000.
REQ-025 Reset SHALL override HTICK, writes and IRQ_ACK in the same cycle.
REQ-026 A reset mid-frame SHALL restart counting from line 0 with no FRAME pulse.

Configuration
REQ-027 With VLINE_IRQ_DBUF_EN defined, compare writes SHALL go to a shadow register, and the shadow SHALL be copied to the active compare on the HTICK that wraps VCNT to 0.
REQ-028 With VLINE_IRQ_DBUF_EN defined, that copy SHALL include a write made in the same cycle, and the line-0 match SHALL use the copied value.
REQ-029 With VLINE_IRQ_DBUF_EN defined, IRQ_EN SHALL remain unbuffered and take effect immediately.
REQ-030 Without VLINE_IRQ_DBUF_EN, writes SHALL update the active compare directly, and a write coincident with HTICK SHALL NOT affect that HTICK's match (the old value is used).

Structure
REQ-031 The shared package vline_pkg SHALL hold: LINE_W = 9; typedef line_t (9-bit unsigned); constants LINE_RST = 0 and CMP_RST = 0.
REQ-032 The equality test SHALL be one sub-module, vline_cmp9: two line_t inputs plus an enable, producing a single equal output. It is purely combinational and is instantiated once.

Verification
REQ-033 VTOTAL = 311, 312 HTICKs from reset -> VCNT runs 0..311 then returns to 0; exactly one FRAME pulse, coincident with VCNT = 0.
REQ-034 Compare = 100, IRQ_EN = 1, HTICKs -> IRQ rises in the cycle in which VCNT = 100; no IRQ on other lines; IRQ_ACK clears it on the next edge.
REQ-035 Compare = 5, IRQ left pending through a second frame -> OVR = 1 at the second line-5 match; IRQ_ACK clears both IRQ and OVR.
REQ-036 IRQ_ACK in the same cycle as a line-5 match -> IRQ = 1, OVR = 0 afterwards.
REQ-037 With VLINE_IRQ_DBUF_EN, write compare = 20 at VCNT = 50 -> CMP_Q stays old until the wrap and no match at line 20 in the current frame; match at line 20 of the next frame. Without the macro -> CMP_Q = 20 immediately.
REQ-038 VTOTAL lowered from 311 to 40 while VCNT = 200 -> the next HTICK gives VCNT = 0 and FRAME = 1; RESETL = 0 at VCNT = 77 -> all outputs reach their reset values on the next edge.

Source files
------------

// File: rtl/vline_pkg.sv
// Shared line-counter types and reset constants for the vertical line interrupt block.
package vline_pkg;
    localparam int LINE_W = 9;
    typedef logic [LINE_W-1:0] line_t;
    localparam line_t LINE_RST = '0;
    localparam line_t CMP_RST  = '0;
endpackage

// File: rtl/vline_cmp9.sv
// Gated 9-bit equality test between the upcoming line number and the compare value.
module vline_cmp9
    import vline_pkg::*;
(
    input  line_t a,
    input  line_t b,
    input  logic  en,
    output logic  eq
);
    assign eq = en && (a == b);
endmodule

// File: rtl/vline_irq.sv
// Vertical line counter with a line-match interrupt, sticky overrun and frame pulse.
// Optional macro VLINE_IRQ_DBUF_EN: compare writes land in a shadow copied to the active compare at frame wrap.
module vline_irq
    import vline_pkg::*;
(
    input  logic       CLK,
    input  logic       RESETL,
    input  logic       HTICK,
    input  logic [8:0] VTOTAL,
    input  logic [7:0] DIN,
    input  logic       WR_LO,
    input  logic       WR_HI,
    input  logic       IRQ_ACK,
    output logic [8:0] VCNT,
    output logic       FRAME,
    output logic [8:0] CMP_Q,
    output logic       IRQ,
    output logic       OVR
);
    line_t vcnt_q, vcnt_d;
    line_t cmp_q, cmp_d;
    logic  frame_q, frame_d;
    logic  irq_q, irq_d;
    logic  ovr_q, ovr_d;
    logic  irq_en_q, irq_en_d;
    logic  wrap;
    line_t wr_val;
    line_t cmp_ref;
    logic  match;
`ifdef VLINE_IRQ_DBUF_EN
    line_t shd_q, shd_d;
`endif

    vline_cmp9 u_cmp (
        .a  (vcnt_d),
        .b  (cmp_ref),
        .en (HTICK && irq_en_q),
        .eq (match)
    );

    always_comb begin
        wrap    = HTICK && (vcnt_q >= line_t'(VTOTAL));
        frame_d = wrap;
        vcnt_d  = vcnt_q;
        if (wrap) begin
            vcnt_d = LINE_RST;
        end else if (HTICK) begin
            vcnt_d = vcnt_q + line_t'(1);
        end

        // Merge byte-lane writes into whichever register the CPU addresses.
`ifdef VLINE_IRQ_DBUF_EN
        wr_val = shd_q;
`else
        wr_val = cmp_q;
`endif
        if (WR_LO) begin
            wr_val[7:0] = DIN;
        end
        if (WR_HI) begin
            wr_val[8] = DIN[0];
        end
        irq_en_d = WR_HI ? DIN[7] : irq_en_q;

`ifdef VLINE_IRQ_DBUF_EN
        shd_d   = wr_val;
        cmp_d   = wrap ? wr_val : cmp_q;
        cmp_ref = cmp_d;
`else
        // A same-cycle write must not influence this line's match.
        cmp_d   = wr_val;
        cmp_ref = cmp_q;
`endif

        irq_d = irq_q;
        if (match) begin
            irq_d = 1'b1;
        end else if (IRQ_ACK) begin
            irq_d = 1'b0;
        end

        ovr_d = ovr_q;
        if (IRQ_ACK) begin
            ovr_d = 1'b0;
        end else if (match && irq_q) begin
            ovr_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESETL) begin
            vcnt_q   <= LINE_RST;
            cmp_q    <= CMP_RST;
            frame_q  <= 1'b0;
            irq_q    <= 1'b0;
            ovr_q    <= 1'b0;
            irq_en_q <= 1'b0;
`ifdef VLINE_IRQ_DBUF_EN
            shd_q    <= CMP_RST;
`endif
        end else begin
            vcnt_q   <= vcnt_d;
            cmp_q    <= cmp_d;
            frame_q  <= frame_d;
            irq_q    <= irq_d;
            ovr_q    <= ovr_d;
            irq_en_q <= irq_en_d;
`ifdef VLINE_IRQ_DBUF_EN
            shd_q    <= shd_d;
`endif
        end
    end

    assign VCNT  = vcnt_q;
    assign FRAME = frame_q;
    assign CMP_Q = cmp_q;
    assign IRQ   = irq_q;
    assign OVR   = ovr_q;
endmodule

// File: tb/tb_vline_irq.sv
// Self-checking bench for vline_irq: directed scenarios plus randomized traffic against a line-level model.
module tb_vline_irq;
    logic       CLK = 1'b0;
    logic       RESETL = 1'b0;
    logic       HTICK = 1'b0;
    logic [8:0] VTOTAL = 9'd311;
    logic [7:0] DIN = 8'h00;
    logic       WR_LO = 1'b0;
    logic       WR_HI = 1'b0;
    logic       IRQ_ACK = 1'b0;
    logic [8:0] VCNT;
    logic       FRAME;
    logic [8:0] CMP_Q;
    logic       IRQ;
    logic       OVR;

    int checks = 0;
    int failures = 0;

    int m_vcnt, m_cmp, m_shd;
    bit m_frame, m_irq, m_ovr, m_en;

    vline_irq dut (
        .CLK     (CLK),
        .RESETL  (RESETL),
        .HTICK   (HTICK),
        .VTOTAL  (VTOTAL),
        .DIN     (DIN),
        .WR_LO   (WR_LO),
        .WR_HI   (WR_HI),
        .IRQ_ACK (IRQ_ACK),
        .VCNT    (VCNT),
        .FRAME   (FRAME),
        .CMP_Q   (CMP_Q),
        .IRQ     (IRQ),
        .OVR     (OVR)
    );

    always #5 CLK = ~CLK;

    // Line-level model: one call per clock edge, applying the behavioural rules directly.
    task automatic model_step(input bit rst_n, input bit ht, input bit lo, input bit hi,
                              input bit ack, input logic [7:0] d, input int vt);
        bit wrap, match;
        int nxt, written, active;
        if (!rst_n) begin
            m_vcnt = 0; m_cmp = 0; m_shd = 0;
            m_frame = 0; m_irq = 0; m_ovr = 0; m_en = 0;
            return;
        end
        wrap = ht && (m_vcnt >= vt);
        nxt = wrap ? 0 : (ht ? (m_vcnt + 1) % 512 : m_vcnt);
`ifdef VLINE_IRQ_DBUF_EN
        written = m_shd;
`else
        written = m_cmp;
`endif
        if (lo) written = (written & 256) + int'(d);
        if (hi) written = (written & 255) + (d[0] ? 256 : 0);
`ifdef VLINE_IRQ_DBUF_EN
        m_shd = written;
        if (wrap) m_cmp = written;
        active = m_cmp;
`else
        active = m_cmp;
        m_cmp = written;
`endif
        match = ht && m_en && (nxt == active);
        if (ack) m_ovr = 0;
        else if (match && m_irq) m_ovr = 1;
        if (match) m_irq = 1;
        else if (ack) m_irq = 0;
        if (hi) m_en = d[7];
        m_frame = wrap;
        m_vcnt = nxt;
    endtask

    task automatic tick(input bit ht, input bit lo, input bit hi, input bit ack, input logic [7:0] d);
        HTICK = ht; WR_LO = lo; WR_HI = hi; IRQ_ACK = ack; DIN = d;
        @(posedge CLK);
        model_step(RESETL, ht, lo, hi, ack, d, int'(VTOTAL));
        #1;
        HTICK = 1'b0; WR_LO = 1'b0; WR_HI = 1'b0; IRQ_ACK = 1'b0;
    endtask

    task automatic run_hticks(input int n);
        repeat (n) tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic do_reset();
        RESETL = 1'b0;
        tick(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        RESETL = 1'b1;
    endtask

    // Writes compare and sets IRQ_EN; with double buffering, runs one frame so it becomes active.
    task automatic program_cmp(input int val);
        logic [8:0] v;
        v = 9'(val);
        tick(1'b0, 1'b1, 1'b0, 1'b0, v[7:0]);
        tick(1'b0, 1'b0, 1'b1, 1'b0, {1'b1, 6'b0, v[8]});
`ifdef VLINE_IRQ_DBUF_EN
        run_hticks(int'(VTOTAL) + 1);
`endif
    endtask

    task automatic test_reset();
        RESETL = 1'b1;
        VTOTAL = 9'd311;
        tick(1'b0, 1'b1, 1'b1, 1'b0, 8'hFF);
        run_hticks(7);
        RESETL = 1'b0;
        tick(1'b1, 1'b1, 1'b1, 1'b1, 8'hAA);
        checks++; if (VCNT !== 9'd0) begin failures++; $display("FAIL reset_vcnt got=%0d exp=0", VCNT); end
        checks++; if (FRAME !== 1'b0) begin failures++; $display("FAIL reset_frame got=%b exp=0", FRAME); end
        checks++; if (CMP_Q !== 9'd0) begin failures++; $display("FAIL reset_cmp got=%0d exp=0", CMP_Q); end
        checks++; if (IRQ !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", IRQ); end
        checks++; if (OVR !== 1'b0) begin failures++; $display("FAIL reset_ovr got=%b exp=0", OVR); end
        RESETL = 1'b1;
    endtask

    task automatic test_frame();
        int frames;
        frames = 0;
        VTOTAL = 9'd311;
        do_reset();
        for (int i = 1; i <= 312; i++) begin
            tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
            if (FRAME === 1'b1) frames++;
            checks++;
            if (VCNT !== 9'(i % 312) || FRAME !== (i == 312)) begin
                failures++;
                $display("FAIL frame_count step=%0d got vcnt=%0d frame=%b exp vcnt=%0d frame=%b",
                         i, VCNT, FRAME, i % 312, (i == 312));
            end
        end
        checks++; if (frames != 1) begin failures++; $display("FAIL frame_pulses got=%0d exp=1", frames); end
    endtask

    task automatic test_match();
        VTOTAL = 9'd311;
        do_reset();
        program_cmp(100);
        for (int i = 1; i < 100; i++) begin
            tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
            checks++; if (IRQ !== 1'b0) begin failures++; $display("FAIL match_early line=%0d irq=%b exp=0", VCNT, IRQ); end
        end
        tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        checks++;
        if (VCNT !== 9'd100 || IRQ !== 1'b1) begin
            failures++; $display("FAIL match_line100 got vcnt=%0d irq=%b exp vcnt=100 irq=1", VCNT, IRQ);
        end
        tick(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        checks++; if (IRQ !== 1'b0) begin failures++; $display("FAIL match_ack irq=%b exp=0", IRQ); end
        for (int i = 0; i < 212; i++) begin
            tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
            checks++; if (IRQ !== 1'b0) begin failures++; $display("FAIL match_other line=%0d irq=%b exp=0", VCNT, IRQ); end
        end
    endtask

    task automatic test_overrun();
        VTOTAL = 9'd311;
        do_reset();
        program_cmp(5);
        run_hticks(5);
        checks++; if (IRQ !== 1'b1 || OVR !== 1'b0) begin failures++; $display("FAIL ovr_first irq=%b ovr=%b exp 1 0", IRQ, OVR); end
        run_hticks(312);
        checks++;
        if (VCNT !== 9'd5 || IRQ !== 1'b1 || OVR !== 1'b1) begin
            failures++; $display("FAIL ovr_second vcnt=%0d irq=%b ovr=%b exp 5 1 1", VCNT, IRQ, OVR);
        end
        tick(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        checks++; if (IRQ !== 1'b0 || OVR !== 1'b0) begin failures++; $display("FAIL ovr_ack irq=%b ovr=%b exp 0 0", IRQ, OVR); end
        run_hticks(312);
        run_hticks(311);
        checks++; if (VCNT !== 9'd4 || IRQ !== 1'b1) begin failures++; $display("FAIL ovr_pending vcnt=%0d irq=%b exp 4 1", VCNT, IRQ); end
        tick(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        checks++;
        if (VCNT !== 9'd5 || IRQ !== 1'b1 || OVR !== 1'b0) begin
            failures++; $display("FAIL ack_with_match vcnt=%0d irq=%b ovr=%b exp 5 1 0", VCNT, IRQ, OVR);
        end
        // Disabling blocks new matches but keeps the pending request.
        tick(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        run_hticks(312);
        checks++;
        if (VCNT !== 9'd5 || IRQ !== 1'b1 || OVR !== 1'b0) begin
            failures++; $display("FAIL en_off vcnt=%0d irq=%b ovr=%b exp 5 1 0", VCNT, IRQ, OVR);
        end
        tick(1'b0, 1'b0, 1'b1, 1'b1, 8'h80);
        tick(1'b0, 1'b1, 1'b0, 1'b0, 8'd5);
        checks++; if (IRQ !== 1'b0) begin failures++; $display("FAIL write_no_irq irq=%b exp=0", IRQ); end
    endtask

    task automatic test_dbuf();
        logic [8:0] exp_cmp;
        VTOTAL = 9'd311;
        do_reset();
        tick(1'b0, 1'b0, 1'b1, 1'b0, 8'h80);
        run_hticks(50);
        tick(1'b0, 1'b1, 1'b0, 1'b0, 8'd20);
`ifdef VLINE_IRQ_DBUF_EN
        exp_cmp = 9'd0;
`else
        exp_cmp = 9'd20;
`endif
        checks++; if (CMP_Q !== exp_cmp) begin failures++; $display("FAIL dbuf_write cmp=%0d exp=%0d", CMP_Q, exp_cmp); end
        run_hticks(261);
        checks++;
        if (VCNT !== 9'd311 || CMP_Q !== exp_cmp || IRQ !== 1'b0) begin
            failures++; $display("FAIL dbuf_hold vcnt=%0d cmp=%0d irq=%b exp 311 %0d 0", VCNT, CMP_Q, IRQ, exp_cmp);
        end
        tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        checks++;
        if (VCNT !== 9'd0 || CMP_Q !== 9'd20 || IRQ !== 1'b0) begin
            failures++; $display("FAIL dbuf_wrap vcnt=%0d cmp=%0d irq=%b exp 0 20 0", VCNT, CMP_Q, IRQ);
        end
        run_hticks(19);
        checks++; if (IRQ !== 1'b0) begin failures++; $display("FAIL dbuf_line19 irq=%b exp=0", IRQ); end
        tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        checks++;
        if (VCNT !== 9'd20 || IRQ !== 1'b1) begin
            failures++; $display("FAIL dbuf_line20 vcnt=%0d irq=%b exp 20 1", VCNT, IRQ);
        end
    endtask

    task automatic test_vtotal_and_reset();
        VTOTAL = 9'd311;
        do_reset();
        program_cmp(10);
        run_hticks(200);
        checks++; if (VCNT !== 9'd200) begin failures++; $display("FAIL vt_pre vcnt=%0d exp=200", VCNT); end
        VTOTAL = 9'd40;
        tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        checks++; if (VCNT !== 9'd0 || FRAME !== 1'b1) begin failures++; $display("FAIL vt_lower vcnt=%0d frame=%b exp 0 1", VCNT, FRAME); end
        VTOTAL = 9'd311;
        run_hticks(77);
        checks++; if (VCNT !== 9'd77 || IRQ !== 1'b1) begin failures++; $display("FAIL vt_mid vcnt=%0d irq=%b exp 77 1", VCNT, IRQ); end
        RESETL = 1'b0;
        tick(1'b1, 1'b1, 1'b1, 1'b1, 8'hFF);
        checks++;
        if (VCNT !== 9'd0 || FRAME !== 1'b0 || CMP_Q !== 9'd0 || IRQ !== 1'b0 || OVR !== 1'b0) begin
            failures++; $display("FAIL mid_reset vcnt=%0d frame=%b cmp=%0d irq=%b ovr=%b exp all 0", VCNT, FRAME, CMP_Q, IRQ, OVR);
        end
        RESETL = 1'b1;
        tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        checks++; if (VCNT !== 9'd1 || FRAME !== 1'b0) begin failures++; $display("FAIL post_reset vcnt=%0d frame=%b exp 1 0", VCNT, FRAME); end
    endtask

    task automatic test_random();
        logic [20:0] exp_v;
        logic [20:0] got_v;
        VTOTAL = 9'd12;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            RESETL = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 99) == 0) VTOTAL = 9'($urandom_range(2, 24));
            tick($urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 7) == 0, {$urandom_range(0, 3) != 0, 7'($urandom_range(0, 24))});
            exp_v = {9'(m_vcnt), m_frame, 9'(m_cmp), m_irq, m_ovr};
            got_v = {VCNT, FRAME, CMP_Q, IRQ, OVR};
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL random step=%0d got vcnt=%0d frame=%b cmp=%0d irq=%b ovr=%b exp vcnt=%0d frame=%b cmp=%0d irq=%b ovr=%b",
                         i, VCNT, FRAME, CMP_Q, IRQ, OVR, m_vcnt, m_frame, m_cmp, m_irq, m_ovr);
            end
        end
        RESETL = 1'b1;
    endtask

    initial begin
        test_reset();
        test_frame();
        test_match();
        test_overrun();
        test_dbuf();
        test_vtotal_and_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
